// File: rtl/peak_hold_multi.sv
// Multi-channel windowed peak detector (abs-peak or signed-max per window).
// Optional peak index output: define PEAK_HOLD_INDEX_EN to add max_idx.
module peak_hold_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 4,
  parameter int WIN_LEN = 150000,
  localparam int CNT_W = $clog2(WIN_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         nd,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic                         mode,
  input  logic                         clr,
  output logic [NUM_CH*DATA_WIDTH-1:0] max_out,
  output logic [NUM_CH-1:0]            sat_flag,
`ifdef PEAK_HOLD_INDEX_EN
  output logic [NUM_CH*CNT_W-1:0]      max_idx,
`endif
  output logic                         max_valid
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MOST_POS = {1'b0, {(W-1){1'b1}}};

  logic [CNT_W-1:0] cnt;
  logic             term;
  logic             mode_q;
  logic             xf_mode;

  logic                      s1_v;
  logic [NUM_CH-1:0][W-1:0]  s1_d;
  logic                      s2_v;
  logic [NUM_CH-1:0][W-1:0]  s2_val;
  logic [NUM_CH-1:0]         s2_sat;

  logic [NUM_CH-1:0][W-1:0]  xf_val;
  logic [NUM_CH-1:0]         xf_sat;

  logic [NUM_CH-1:0][W-1:0]  run;
  logic [NUM_CH-1:0]         sticky;
  logic [NUM_CH-1:0]         upd;
  logic [NUM_CH-1:0][W-1:0]  cand;
  logic [NUM_CH-1:0]         sat_in;
  logic [NUM_CH-1:0][W-1:0]  max_q;

`ifdef PEAK_HOLD_INDEX_EN
  logic [NUM_CH-1:0][CNT_W-1:0] run_idx;
  logic [NUM_CH-1:0][CNT_W-1:0] idx_q;
  assign max_idx = idx_q;
`endif

  function automatic logic [W-1:0] init_of(input logic m);
    return m ? MOST_NEG : '0;
  endfunction

  assign term    = (cnt == CNT_W'(WIN_LEN - 1));
  // A sample entering S2 on the terminal edge belongs to the next window,
  // so it is transformed with the mode that window will use.
  assign xf_mode = term ? mode : mode_q;
  assign max_out = max_q;

  // Window counter and per-window mode capture
  always_ff @(posedge clk) begin
    if (rst || clr || term) begin
      cnt    <= '0;
      mode_q <= mode;
    end else begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // S1: capture qualified samples
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_d <= '0;
    end else begin
      s1_v <= nd & ~clr;
      if (nd) s1_d <= data_in;
    end
  end

  // S2 transform: abs with saturation of the most-negative code, or pass
  always_comb begin
    xf_val = s1_d;
    xf_sat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!xf_mode && s1_d[c][W-1]) begin
        if (s1_d[c] == MOST_NEG) begin
          xf_val[c] = MOST_POS;
          xf_sat[c] = 1'b1;
        end else begin
          xf_val[c] = -s1_d[c];
        end
      end
    end
  end

  // S2 register
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s2_v   <= 1'b0;
      s2_val <= '0;
      s2_sat <= '0;
    end else begin
      s2_v   <= s1_v;
      s2_val <= xf_val;
      s2_sat <= xf_sat;
    end
  end

  // S3 compare: strictly greater wins, so ties keep the earlier sample
  always_comb begin
    upd  = '0;
    cand = run;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s2_v) begin
        if (mode_q)
          upd[c] = $signed(s2_val[c]) > $signed(run[c]);
        else
          upd[c] = s2_val[c] > run[c];
      end
      if (upd[c]) cand[c] = s2_val[c];
    end
    sat_in = s2_v ? s2_sat : '0;
  end

  // Running max and sticky saturation, restarted every window
  always_ff @(posedge clk) begin
    if (rst || clr || term) begin
      for (int c = 0; c < NUM_CH; c++) run[c] <= init_of(mode);
      sticky <= '0;
`ifdef PEAK_HOLD_INDEX_EN
      run_idx <= '0;
`endif
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (upd[c]) begin
          run[c] <= s2_val[c];
`ifdef PEAK_HOLD_INDEX_EN
          run_idx[c] <= cnt;
`endif
        end
      end
      sticky <= sticky | sat_in;
    end
  end

  // Publish at the terminal edge, folding in the in-flight sample
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q     <= '0;
      sat_flag  <= '0;
      max_valid <= 1'b0;
`ifdef PEAK_HOLD_INDEX_EN
      idx_q     <= '0;
`endif
    end else begin
      max_valid <= term & ~clr;
      if (term && !clr) begin
        max_q    <= cand;
        sat_flag <= sticky | sat_in;
`ifdef PEAK_HOLD_INDEX_EN
        for (int c = 0; c < NUM_CH; c++)
          idx_q[c] <= upd[c] ? cnt : run_idx[c];
`endif
      end
    end
  end

endmodule
